// File: rtl/store_buffer.sv
// store_buffer: in-order circular store buffer between the core memory stage and data memory
// Ports: clk/reset (async, active-low); MemWriteM/DataAdrM/WriteDataM store request, StallM full;
//        LoadAdrM lookup address, FwdHitM/FwdDataM forwarding result; mem_valid/mem_ready/
//        mem_addr/mem_wdata head entry to memory; Count occupancy; Drained empty.
// Macro STORE_BUFFER_FORWARD_EN enables store-to-load forwarding; otherwise FwdHitM/FwdDataM are 0.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWriteM,
  input  logic [AW-1:0]          DataAdrM,
  input  logic [DW-1:0]          WriteDataM,
  output logic                   StallM,
  input  logic [AW-1:0]          LoadAdrM,
  output logic                   FwdHitM,
  output logic [DW-1:0]          FwdDataM,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Drained
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic enq, deq;
  assign StallM = count_q == CW'(DEPTH);
  assign mem_valid = count_q != '0;
  assign Drained = count_q == '0;
  assign Count = count_q;
  assign mem_addr = addr_q[rd_ptr_q];
  assign mem_wdata = data_q[rd_ptr_q];
  assign enq = MemWriteM && !StallM;
  assign deq = mem_valid && mem_ready;
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (enq) begin
      addr_d[wr_ptr_q] = DataAdrM;
      data_d[wr_ptr_q] = WriteDataM;
    end
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(enq) - CW'(deq);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
`ifdef STORE_BUFFER_FORWARD_EN
  // Scan from oldest to youngest so the last match wins; only registered entries are searched.
  always_comb begin
    FwdHitM = 1'b0;
    FwdDataM = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && addr_q[rd_ptr_q + PW'(k)] == LoadAdrM) begin
        FwdHitM = 1'b1;
        FwdDataM = data_q[rd_ptr_q + PW'(k)];
      end
    end
  end
`else
  logic unused_load;
  assign unused_load = ^LoadAdrM;
  assign FwdHitM = 1'b0;
  assign FwdDataM = '0;
`endif
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 MemWriteM  input  1  core memory stage requests a store this cycle.
REQ-007 DataAdrM  input  AW  store address from core memory stage.
REQ-008 WriteDataM  input  DW  store data from core memory stage.
REQ-009 StallM  output  1  buffer full; core must hold the store.
REQ-010 LoadAdrM  input  AW  load address presented for forwarding lookup.
REQ-011 FwdHitM  output  1  a buffered store matches LoadAdrM.
REQ-012 FwdDataM  output  DW  data of youngest matching buffered store.
REQ-013 mem_valid  output  1  head entry offered to data memory.
REQ-014 mem_ready  input  1  data memory accepts the head entry.
REQ-015 mem_addr  output  AW  head entry address.
REQ-016 mem_wdata  output  DW  head entry data.
REQ-017 Count  output  clog2(DEPTH)+1  current occupancy.
REQ-018 Drained  output  1  buffer empty; used by fences and the bench.

Function
REQ-019 Circular FIFO with write pointer, read pointer and occupancy; pointers wrap modulo DEPTH.
REQ-020 Enqueue on a rising edge when MemWriteM=1 and Count<DEPTH; entry stores DataAdrM and WriteDataM unmodified.
REQ-021 StallM is combinational and equals (Count==DEPTH), independent of mem_ready in the same cycle.
REQ-022 MemWriteM=1 while StallM=1 causes no enqueue and no state change; the core holds and retries.
REQ-023 mem_valid equals (Count!=0); mem_addr and mem_wdata reflect the head entry combinationally.
REQ-024 Dequeue on a rising edge when mem_valid=1 and mem_ready=1.
REQ-025 While mem_valid=1 and mem_ready=0, mem_addr and mem_wdata remain stable.
REQ-026 mem_ready while empty is ignored.
REQ-027 Simultaneous enqueue and dequeue: Count unchanged, both pointers advance.
REQ-028 Enqueue-to-mem_valid latency is 1 cycle; a store into an empty buffer is never bypassed combinationally to memory.
REQ-029 Drained equals (Count==0).
REQ-030 Stores drain in strict program order; each store reaches memory exactly once.

Reset
REQ-031 reset=0 asynchronously clears pointers and Count and zeroes all entries.
REQ-032 During reset and after deassertion: StallM=0, mem_valid=0, mem_addr=0, mem_wdata=0, FwdHitM=0, FwdDataM=0, Count=0, Drained=1.
REQ-033 Reset asserted mid-drain discards all pending stores; no further mem_valid until a new enqueue.
REQ-034 Reset deassertion is synchronised externally; the first enqueue is legal on the first rising edge after deassertion.

Configuration
REQ-035 Macro STORE_BUFFER_FORWARD_EN selects store-to-load forwarding.
REQ-036 With STORE_BUFFER_FORWARD_EN defined: FwdHitM=1 when any valid entry address equals LoadAdrM; FwdDataM is the youngest match's data; lookup is combinational; a store enqueueing in the same cycle is not visible.
REQ-037 Without STORE_BUFFER_FORWARD_EN: LoadAdrM ignored; FwdHitM and FwdDataM tied to 0; all other behaviour unchanged.

Verification
REQ-038 Reset released; MemWriteM=1, DataAdrM=100, WriteDataM=7 for one cycle; mem_ready=1 -> next cycle mem_valid=1, mem_addr=100, mem_wdata=7; following cycle Drained=1.
REQ-039 mem_ready=0; stores to 96, 100, 104, 108 with data 1..4 -> Count=4, StallM=1; fifth store (112, 5) not accepted; mem_ready=1 -> memory receives 96, 100, 104, 108 in order; 112 accepted after first dequeue.
REQ-040 Count=2, MemWriteM=1 and mem_ready=1 in the same cycle -> Count stays 2; order preserved across pointer wrap after 10 such cycles.
REQ-041 Forwarding enabled, mem_ready=0; store 96<-3 then 96<-9; LoadAdrM=96 -> FwdHitM=1, FwdDataM=9; LoadAdrM=100 -> FwdHitM=0; macro undefined -> FwdHitM=0 in both cases.
REQ-042 Three stores pending, mem_ready=0, reset pulsed low mid-cycle -> outputs zero immediately; after release, mem_valid stays 0 until a new store.
